// File: rtl/ser_tx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ser_tx_ctrl
// Brief    : Async-serial frame sequencer driving a flex_pts_sr (LSB first).
//            Optional even parity bit enabled by macro SER_TX_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module ser_tx_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
`ifdef SER_TX_PARITY_EN
    localparam int FRAME_W     = DATA_BITS + 3
`else
    localparam int FRAME_W     = DATA_BITS + 2
`endif
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 load_enable,
    output logic                 shift_enable,
    output logic [FRAME_W-1:0]   tx_word,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam int BIT_W = $clog2(FRAME_W);
    localparam int CLK_W = $clog2(CLKS_PER_BIT);

    localparam logic [1:0]         c_IDLE      = 2'd0;
    localparam logic [1:0]         c_LOAD      = 2'd1;
    localparam logic [1:0]         c_BIT       = 2'd2;
    localparam logic [BIT_W-1:0]   c_BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [CLK_W-1:0]   c_CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [FRAME_W-1:0] c_IDLE_WORD = {FRAME_W{1'b1}};

    logic [1:0]           r_state;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [CLK_W-1:0]     r_clk_cnt;
    logic [DATA_BITS-1:0] r_data_q;

    logic                 w_bit_end;
    logic                 w_stop_end;
    logic [FRAME_W-1:0]   w_frame;

    assign w_bit_end  = (r_state == c_BIT) && (r_clk_cnt == c_CLK_LAST);
    assign w_stop_end = w_bit_end && (r_bit_cnt == c_BIT_LAST);

`ifdef SER_TX_PARITY_EN
    assign w_frame = {1'b1, ^r_data_q, r_data_q, 1'b0};
`else
    assign w_frame = {1'b1, r_data_q, 1'b0};
`endif

    // Stop-bit end reloads all ones so the line idles high after the PTS
    // register has shifted zeros in from the top.
    assign data_ready   = (r_state == c_IDLE);
    assign tx_busy      = (r_state != c_IDLE);
    assign load_enable  = (r_state == c_LOAD) || w_stop_end;
    assign shift_enable = w_bit_end && !w_stop_end;
    assign frame_done   = w_stop_end;
    assign tx_word      = (r_state == c_LOAD) ? w_frame : c_IDLE_WORD;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= '0;
            r_clk_cnt <= '0;
            r_data_q  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (data_valid) begin
                        r_data_q <= data_in;
                        r_state  <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_state   <= c_BIT;
                    r_bit_cnt <= '0;
                    r_clk_cnt <= '0;
                end
                c_BIT: begin
                    if (r_clk_cnt == c_CLK_LAST) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CLK_W'(1);
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_bit_cnt <= '0;
                    r_clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ser_tx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ser_tx_ctrl
// Brief    : Table-driven bench for ser_tx_ctrl with a PTS line model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ser_tx_ctrl;

`ifdef SER_TX_PARITY_EN
    localparam int FW = 11;
    localparam logic [FW-1:0] W_A5 = 11'h54A, W_00 = 11'h400, W_FF = 11'h5FE,
                              W_07 = 11'h60E, W_3C = 11'h478, W_5A = 11'h4B4;
`else
    localparam int FW = 10;
    localparam logic [FW-1:0] W_A5 = 10'h34A, W_00 = 10'h200, W_FF = 10'h3FE,
                              W_07 = 10'h20E, W_3C = 10'h278, W_5A = 10'h2B4;
`endif
    localparam logic [FW-1:0] ONES = {FW{1'b1}};

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          valid1 = 1'b0, valid2 = 1'b0;
    logic          sel = 1'b0;

    logic          rdy1, ld1, sh1, busy1, done1;
    logic          rdy2, ld2, sh2, busy2, done2;
    logic [FW-1:0] word1, word2, sr1, sr2;
    logic          m_rdy, m_ld, m_sh, m_busy, m_done, m_ser;
    logic [FW-1:0] m_word;

    int n_chk = 0;
    int n_err = 0;
    int cur_k = 0;

    always #5 clk = ~clk;

    ser_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(10)) dut (
        .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(valid1),
        .data_ready(rdy1), .load_enable(ld1), .shift_enable(sh1),
        .tx_word(word1), .tx_busy(busy1), .frame_done(done1));

    ser_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(2)) dut_fast (
        .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(valid2),
        .data_ready(rdy2), .load_enable(ld2), .shift_enable(sh2),
        .tx_word(word2), .tx_busy(busy2), .frame_done(done2));

    // Downstream PTS register: loads parallel word, shifts right with zero fill.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr1 <= ONES;
            sr2 <= ONES;
        end else begin
            if (ld1)      sr1 <= word1;
            else if (sh1) sr1 <= {1'b0, sr1[FW-1:1]};
            if (ld2)      sr2 <= word2;
            else if (sh2) sr2 <= {1'b0, sr2[FW-1:1]};
        end
    end

    always_comb begin
        m_rdy  = sel ? rdy2  : rdy1;
        m_ld   = sel ? ld2   : ld1;
        m_sh   = sel ? sh2   : sh1;
        m_busy = sel ? busy2 : busy1;
        m_done = sel ? done2 : done1;
        m_word = sel ? word2 : word1;
        m_ser  = sel ? sr2[0] : sr1[0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d actual=%0h expected=%0h", name, cur_k, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, m_rdy, 1);
        chk({tag, "_busy"},  m_busy, 0);
        chk({tag, "_load"},  m_ld, 0);
        chk({tag, "_shift"}, m_sh, 0);
        chk({tag, "_done"},  m_done, 0);
        chk({tag, "_word"},  m_word, ONES);
        chk({tag, "_serial"}, m_ser, 1);
    endtask

    // Sends one byte and checks every cycle from LOAD through the IDLE cycle after.
    task automatic run_frame(input logic [7:0] d, input logic [FW-1:0] w, input bit fast,
                             input bit hold, input logic [7:0] nxt, input bit immediate);
        int cpb, waited, shifts, done_k, total, j, b, c;
        bit last;
        cpb = fast ? 2 : 10;
        sel = fast;
        data_in = d;
        if (fast) valid2 = 1'b1; else valid1 = 1'b1;
        waited = 0;
        while (!m_rdy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        cur_k = 0;
        chk("accept_ready", m_rdy, 1);
        if (immediate) chk("b2b_wait", waited, 0);
        @(posedge clk);
        total = 1 + FW * cpb;
        shifts = 0;
        done_k = 0;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            cur_k = k;
            if (k == 1) begin
                if (!hold) begin
                    valid1 = 1'b0;
                    valid2 = 1'b0;
                end
                data_in = nxt;
                chk("ld_load", m_ld, 1);
                chk("ld_word", m_word, w);
                chk("ld_shift", m_sh, 0);
                chk("ld_ready", m_rdy, 0);
                chk("ld_busy", m_busy, 1);
                chk("ld_done", m_done, 0);
                chk("ld_serial", m_ser, 1);
            end else if (k <= total) begin
                j = k - 2;
                b = j / cpb;
                c = j % cpb;
                last = (c == cpb - 1);
                chk("bit_shift", m_sh, last && (b < FW - 1));
                chk("bit_load", m_ld, last && (b == FW - 1));
                chk("bit_done", m_done, last && (b == FW - 1));
                chk("bit_word", m_word, ONES);
                chk("bit_ready", m_rdy, 0);
                chk("bit_busy", m_busy, 1);
                chk("bit_serial", m_ser, w[b]);
                if (m_sh) shifts++;
                if (m_done) done_k = k;
            end else begin
                chk_idle("post");
            end
        end
        chk("shift_count", shifts, FW - 1);
        chk("done_after_load", done_k - 1, FW * cpb);
    endtask

    typedef struct {
        logic [7:0]    data;
        logic [FW-1:0] word;
        bit            fast;
        bit            hold;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int sh_seen, guard;
        logic [7:0] nxt;
        bit imm;

        tbl[0] = '{8'hA5, W_A5, 1'b0, 1'b0};
        tbl[1] = '{8'h00, W_00, 1'b0, 1'b1};
        tbl[2] = '{8'hFF, W_FF, 1'b0, 1'b0};
        tbl[3] = '{8'h07, W_07, 1'b0, 1'b0};
        tbl[4] = '{8'h3C, W_3C, 1'b1, 1'b0};

        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("in_reset");
        n_rst = 1'b1;
        @(negedge clk);
        chk_idle("after_reset");

        for (int i = 0; i < 5; i++) begin
            nxt = (tbl[i].hold && i < 4) ? tbl[i+1].data : ~tbl[i].data;
            imm = (i > 0) && tbl[i-1].hold;
            run_frame(tbl[i].data, tbl[i].word, tbl[i].fast, tbl[i].hold, nxt, imm);
        end

        // Mid-frame reset one cycle after the third shift pulse.
        sel = 1'b0;
        data_in = 8'hC3;
        valid1 = 1'b1;
        guard = 0;
        while (!m_rdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        valid1 = 1'b0;
        sh_seen = 0;
        guard = 0;
        while (sh_seen < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (m_sh) sh_seen++;
        end
        chk("rst_third_shift", sh_seen, 3);
        @(negedge clk);
        chk("rst_pre_serial", m_ser, 0);
        n_rst = 1'b0;
        #1;
        chk_idle("midframe_rst");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_release");
        run_frame(8'h5A, W_5A, 1'b0, 1'b0, 8'hA5, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog k=%0d actual=timeout expected=finish", cur_k);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
